// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared core definitions: fetch FSM encoding, NOP word,
//               reset PC default and base RV64 opcode constants.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

    // Fetch FSM state encoding
    localparam logic [1:0] c_ST_BOOT = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_HOLD = 2'd2;
    localparam logic [1:0] c_ST_DROP = 2'd3;

    localparam logic [31:0] c_NOP_INSTR      = 32'h0000_0013;
    localparam logic [63:0] c_RESET_PC_DFLT  = 64'h0000_0000_0000_0000;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] c_OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] c_OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] c_OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] c_OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] c_OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] c_OPC_STORE    = 7'b0100011;
    localparam logic [6:0] c_OPC_OP       = 7'b0110011;
    localparam logic [6:0] c_OPC_LUI      = 7'b0110111;
    localparam logic [6:0] c_OPC_OP32     = 7'b0111011;
    localparam logic [6:0] c_OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] c_OPC_JALR     = 7'b1100111;
    localparam logic [6:0] c_OPC_JAL      = 7'b1101111;
    localparam logic [6:0] c_OPC_SYSTEM   = 7'b1110011;

endpackage

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Single-outstanding instruction fetch with redirect handling
//               and a one-entry output register toward decode.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = c_RESET_PC_DFLT,
    parameter logic [31:0] NOP_INSTR = c_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    input  logic        id_ready,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [63:0] if_pc,
    output logic [31:0] if_instr
);

    localparam logic [63:0] c_RESET_PC_ALIGNED = RESET_PC & ~64'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [63:0] r_pc;
    logic [63:0] r_addr;
    logic        r_valid;
    logic [63:0] r_if_pc;
    logic [31:0] r_if_instr;

    logic [63:0] w_redir_pc;
    logic [63:0] w_pc_inc;

    assign w_redir_pc = redirect_pc & ~64'd3;
    assign w_pc_inc   = r_addr + 64'd4;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; redirect outranks ack and id_ready everywhere
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_BOOT: w_state_nxt = c_ST_WAIT;
            c_ST_WAIT: begin
                if (redirect && !imem_ack) begin
                    w_state_nxt = c_ST_DROP;
                end else if (redirect) begin
                    w_state_nxt = c_ST_WAIT;
                end else if (imem_ack) begin
                    w_state_nxt = c_ST_HOLD;
                end
            end
            c_ST_HOLD: begin
                if (redirect || id_ready) begin
                    w_state_nxt = c_ST_WAIT;
                end
            end
            c_ST_DROP: begin
                if (imem_ack) begin
                    w_state_nxt = c_ST_WAIT;
                end
            end
            default: w_state_nxt = c_ST_BOOT;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req = (r_state == c_ST_WAIT) || (r_state == c_ST_DROP);
    end

    // PC, request address and decode-facing output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= c_RESET_PC_ALIGNED;
            r_addr     <= c_RESET_PC_ALIGNED;
            r_valid    <= 1'b0;
            r_if_pc    <= 64'd0;
            r_if_instr <= NOP_INSTR;
        end else begin
            case (r_state)
                c_ST_BOOT: begin
                    if (redirect) begin
                        r_pc   <= w_redir_pc;
                        r_addr <= w_redir_pc;
                    end else begin
                        r_addr <= r_pc;
                    end
                end
                c_ST_WAIT: begin
                    if (redirect) begin
                        r_pc <= w_redir_pc;
                        if (imem_ack) begin
                            r_addr <= w_redir_pc;
                        end
                    end else if (imem_ack) begin
                        r_valid    <= 1'b1;
                        r_if_pc    <= r_addr;
                        r_if_instr <= imem_rdata;
                        r_pc       <= w_pc_inc;
                    end
                end
                c_ST_HOLD: begin
                    if (redirect || id_ready) begin
                        r_valid    <= 1'b0;
                        r_if_pc    <= 64'd0;
                        r_if_instr <= NOP_INSTR;
                        r_addr     <= redirect ? w_redir_pc : r_pc;
                    end
                    if (redirect) begin
                        r_pc <= w_redir_pc;
                    end
                end
                default: begin
                    // DROP: the pending ack belongs to a stale address
                    if (redirect) begin
                        r_pc <= w_redir_pc;
                    end
                    if (imem_ack) begin
                        r_addr <= redirect ? w_redir_pc : r_pc;
                    end
                end
            endcase
        end
    end

    assign imem_addr = r_addr;
    assign if_valid  = r_valid;
    assign if_pc     = r_if_pc;
    assign if_instr  = r_if_instr;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit with a
//               programmable-latency instruction memory responder.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        id_ready;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_instr;

    int n_checks = 0;
    int n_errors = 0;
    int lat      = 0;
    int cnt      = 0;

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .id_ready   (id_ready),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_instr   (if_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: a known word at 0, an address-derived word elsewhere
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a == 64'd0) ? 32'h0050_0093 : (a[31:0] ^ 32'h1357_0000);
    endfunction

    // Responder acks after lat cycles of an outstanding request
    always @(posedge clk) begin
        if (rst || !imem_req || imem_ack) cnt <= 0;
        else                              cnt <= cnt + 1;
    end
    assign imem_ack   = imem_req && (cnt == lat);
    assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [63:0] pc,
                           input logic [31:0] ins);
        chk({tag, "_valid"}, {63'd0, if_valid}, {63'd0, v});
        chk({tag, "_pc"},    if_pc, pc);
        chk({tag, "_instr"}, {32'd0, if_instr}, {32'd0, ins});
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = 64'd0; id_ready = 1'b0;
        step(); step();
        chk("rst_req", {63'd0, imem_req}, 64'd0);
        chk("rst_addr", imem_addr, 64'd0);
        chk_out("rst", 1'b0, 64'd0, 32'h0000_0013);

        // Boot with zero-wait memory
        rst = 1'b0;
        chk("boot_req", {63'd0, imem_req}, 64'd0);
        step();
        chk("c1_req", {63'd0, imem_req}, 64'd1);
        chk("c1_addr", imem_addr, 64'd0);
        step();
        chk_out("c2", 1'b1, 64'd0, 32'h0050_0093);

        // Decode stall: outputs frozen, no request
        for (int i = 0; i < 5; i++) begin
            chk("stall_req", {63'd0, imem_req}, 64'd0);
            chk_out("stall", 1'b1, 64'd0, 32'h0050_0093);
            step();
        end
        id_ready = 1'b1;
        step();
        chk("resume_req", {63'd0, imem_req}, 64'd1);
        chk("resume_addr", imem_addr, 64'd4);
        chk_out("resume", 1'b0, 64'd0, 32'h0000_0013);
        step();
        chk_out("f4", 1'b1, 64'd4, mem_word(64'd4));
        step();
        chk("f8_addr", imem_addr, 64'd8);
        step();
        chk_out("f8", 1'b1, 64'd8, mem_word(64'd8));

        // Redirect while waiting on a 3-cycle memory
        lat = 3;
        step();
        chk("wC_addr", imem_addr, 64'hC);
        id_ready = 1'b0;
        step();
        redirect = 1'b1; redirect_pc = 64'h80;
        step();
        redirect = 1'b0;
        chk("drop_req", {63'd0, imem_req}, 64'd1);
        chk("drop_addr", imem_addr, 64'hC);
        step();
        chk("drop_ack", {63'd0, imem_ack}, 64'd1);
        chk("drop_valid", {63'd0, if_valid}, 64'd0);
        step();
        chk("after_drop_addr", imem_addr, 64'h80);
        chk("after_drop_valid", {63'd0, if_valid}, 64'd0);
        begin
            int k = 0;
            while (!if_valid && k < 10) begin
                step();
                k++;
            end
            chk("redir_timeout", {63'd0, if_valid}, 64'd1);
        end
        chk_out("f80", 1'b1, 64'h80, mem_word(64'h80));

        // Redirect coincident with ack; misaligned target
        lat = 0;
        id_ready = 1'b1;
        step();
        chk("w84_ack", {63'd0, imem_ack}, 64'd1);
        redirect = 1'b1; redirect_pc = 64'h103; id_ready = 1'b0;
        step();
        redirect = 1'b0;
        chk("coinc_addr", imem_addr, 64'h100);
        chk("coinc_valid", {63'd0, if_valid}, 64'd0);
        step();
        chk_out("f100", 1'b1, 64'h100, mem_word(64'h100));

        // Redirect beats id_ready in HOLD; top-of-space wrap
        redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; id_ready = 1'b1;
        step();
        redirect = 1'b0; id_ready = 1'b0;
        chk("top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        chk_out("ftop", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'hECA8_FFFC);
        id_ready = 1'b1;
        step();
        chk("wrap_addr", imem_addr, 64'd0);
        id_ready = 1'b0;
        step();
        chk_out("fwrap", 1'b1, 64'd0, 32'h0050_0093);

        // Redirects inside DROP only retarget the PC
        lat = 3; id_ready = 1'b1;
        step();
        chk("w4_addr", imem_addr, 64'd4);
        id_ready = 1'b0; redirect = 1'b1; redirect_pc = 64'h200;
        step();
        redirect_pc = 64'h300;
        step();
        redirect = 1'b0;
        chk("drop2_addr", imem_addr, 64'd4);
        chk("drop2_req", {63'd0, imem_req}, 64'd1);
        step();
        step();
        chk("drop2_next", imem_addr, 64'h300);

        // Reset while in DROP
        redirect = 1'b1; redirect_pc = 64'h400;
        step();
        redirect = 1'b0;
        chk("drop3_addr", imem_addr, 64'h300);
        rst = 1'b1;
        step();
        chk("rdrop_req", {63'd0, imem_req}, 64'd0);
        chk("rdrop_addr", imem_addr, 64'd0);
        chk_out("rdrop", 1'b0, 64'd0, 32'h0000_0013);
        rst = 1'b0;
        step();
        step();
        chk("rel_req", {63'd0, imem_req}, 64'd1);
        chk("rel_addr", imem_addr, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
